core_sequencer: RTL

- Multi-cycle FSM that sequences the RV32I datapath around the existing combinational control_unit.
- Handles instruction fetch with an imem handshake, inst latch, execute, optional data-memory access with a dmem handshake, and gated register/PC write-back.
- Lets the decoder's single-cycle control outputs drive a core with wait-stated memories.
- Provides a retired-instruction counter and a sticky trap on illegal opcodes or bus timeouts.

---
 rtl/core_sequencer_if.sv | 39 +++
 rtl/core_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/core_sequencer_if.sv
// Bus bundle between core_sequencer and the RV32I datapath/memories.
// master is the sequencer side; slave is the datapath/memory side.
interface core_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic             imem_ready;
  logic             dmem_ready;
  logic [6:0]       opcode;
  logic             cu_mem_read;
  logic             cu_mem_write;
  logic             cu_reg_write;
  logic [1:0]       cu_pc_select;
  logic             imem_req;
  logic             ir_load;
  logic             dmem_req;
  logic             dmem_we;
  logic             rf_we;
  logic             pc_we;
  logic [1:0]       pc_sel;
  logic             retire;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [2:0]       state_o;
  logic [CNT_W-1:0] instret;

  modport master (
    input  imem_ready, dmem_ready, opcode, cu_mem_read, cu_mem_write, cu_reg_write,
           cu_pc_select,
    output imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire, trap,
           trap_cause, state_o, instret
  );

  modport slave (
    output imem_ready, dmem_ready, opcode, cu_mem_read, cu_mem_write, cu_reg_write,
           cu_pc_select,
    input  imem_req, ir_load, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire, trap,
           trap_cause, state_o, instret
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer wrapping the combinational RV32I control_unit: fetch, decode,
// execute, optional data access and gated write-back, with retire count and sticky trap.
module core_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  core_sequencer_if.master io_bus
);

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StTrap    = 3'd5
  } state_e;

  state_e           r_state, w_state_d;
  logic [WaitW-1:0] r_wait, w_wait_d;
  logic [CNT_W-1:0] r_instret;
  logic             r_trap, w_trap_d;
  logic [1:0]       r_cause, w_cause_d;

  logic       w_legal;
  logic       w_go_trap;
  logic [1:0] w_new_cause;
  logic       w_wait_inc;
  logic       w_imem_req, w_ir_load, w_dmem_req, w_dmem_we;
  logic       w_rf_we, w_pc_we, w_retire;
  logic [1:0] w_pc_sel;

  always_comb begin
    w_legal = 1'b0;
    case (io_bus.opcode)
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: w_legal = 1'b1;
      default:                                        w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_state_d   = r_state;
    w_go_trap   = 1'b0;
    w_new_cause = 2'b00;
    w_wait_inc  = 1'b0;
    w_imem_req  = 1'b0;
    w_ir_load   = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_rf_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_sel    = 2'b00;
    w_retire    = 1'b0;

    case (r_state)
      StFetch: begin
        w_imem_req = 1'b1;
        // A ready on the timeout cycle still counts as a successful fetch.
        if (io_bus.imem_ready) begin
          w_ir_load = 1'b1;
          w_state_d = StDecode;
        end else if (r_wait == WaitMax) begin
          w_go_trap   = 1'b1;
          w_new_cause = 2'b10;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      StDecode: begin
        if (!w_legal || (io_bus.cu_mem_read && io_bus.cu_mem_write)) begin
          w_go_trap   = 1'b1;
          w_new_cause = 2'b01;
        end else begin
          w_state_d = StExecute;
        end
      end
      StExecute: begin
        w_state_d = (io_bus.cu_mem_read || io_bus.cu_mem_write) ? StMem : StWb;
      end
      StMem: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = io_bus.cu_mem_write;
        if (io_bus.dmem_ready) begin
          w_state_d = StWb;
        end else if (r_wait == WaitMax) begin
          w_go_trap   = 1'b1;
          w_new_cause = 2'b11;
        end else begin
          w_wait_inc = 1'b1;
        end
      end
      StWb: begin
        w_pc_we   = 1'b1;
        w_pc_sel  = io_bus.cu_pc_select;
        w_rf_we   = io_bus.cu_reg_write;
        w_retire  = 1'b1;
        w_state_d = StFetch;
      end
      StTrap: begin
        w_state_d = StTrap;
      end
      default: begin
        w_go_trap   = 1'b1;
        w_new_cause = 2'b01;
      end
    endcase

    w_trap_d  = r_trap;
    w_cause_d = r_cause;
    if (w_go_trap) begin
      w_state_d = StTrap;
      w_trap_d  = 1'b1;
      w_cause_d = w_new_cause;
    end

    if (w_state_d != r_state) begin
      w_wait_d = '0;
    end else if (w_wait_inc && (r_wait != WaitMax)) begin
      w_wait_d = r_wait + WaitW'(1);
    end else begin
      w_wait_d = r_wait;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StFetch;
      r_wait    <= '0;
      r_instret <= '0;
      r_trap    <= 1'b0;
      r_cause   <= 2'b00;
    end else begin
      r_state <= w_state_d;
      r_wait  <= w_wait_d;
      r_trap  <= w_trap_d;
      r_cause <= w_cause_d;
      if (w_retire) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  // Strobes are forced low while reset is held so an aborted instruction writes nothing.
  assign io_bus.imem_req   = w_imem_req & ~i_rst;
  assign io_bus.ir_load    = w_ir_load & ~i_rst;
  assign io_bus.dmem_req   = w_dmem_req & ~i_rst;
  assign io_bus.dmem_we    = w_dmem_we & ~i_rst;
  assign io_bus.rf_we      = w_rf_we & ~i_rst;
  assign io_bus.pc_we      = w_pc_we & ~i_rst;
  assign io_bus.pc_sel     = w_pc_sel & {2{~i_rst}};
  assign io_bus.retire     = w_retire & ~i_rst;
  assign io_bus.trap       = r_trap;
  assign io_bus.trap_cause = r_cause;
  assign io_bus.state_o    = r_state;
  assign io_bus.instret    = r_instret;

endmodule
